// File: rtl/mp_ingress_arb_if.sv
// Handshake bundle for mp_ingress_arb: per-port framed write streams, per-port
// flow control / status, and the single arbitrated output stream.
interface mp_ingress_arb_if #(
  parameter int IN_PORT_NUM = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int PW          = $clog2(IN_PORT_NUM)
);
  logic [IN_PORT_NUM-1:0] wr_sop;
  logic [IN_PORT_NUM-1:0] wr_eop;
  logic [IN_PORT_NUM-1:0] wr_vld;
  logic [DATA_WIDTH-1:0]  wr_data [IN_PORT_NUM];
  logic [IN_PORT_NUM-1:0] ready;
  logic                   out_vld;
  logic                   out_rdy;
  logic                   out_sop;
  logic                   out_eop;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [PW-1:0]          out_port;
  logic [IN_PORT_NUM-1:0] ovf;
  logic [IN_PORT_NUM-1:0] frm_err;

  modport master (
    output wr_sop, wr_eop, wr_vld, wr_data, out_rdy,
    input  ready, out_vld, out_sop, out_eop, out_data, out_port, ovf, frm_err
  );

  modport slave (
    input  wr_sop, wr_eop, wr_vld, wr_data, out_rdy,
    output ready, out_vld, out_sop, out_eop, out_data, out_port, ovf, frm_err
  );
endinterface

// File: rtl/mp_ingress_arb.sv
// Multi-port ingress stage: per-port show-ahead FIFOs with almost-full ready,
// packet-granular round-robin onto one output. Optional MPCACHE_FRM_CHECK_EN adds framing checks.
module mp_ingress_arb #(
  parameter int IN_PORT_NUM = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 32,
  parameter int AF_MARGIN   = 4,
  parameter int PW          = $clog2(IN_PORT_NUM)
) (
  input  logic              clk,
  input  logic              rst_in,
  mp_ingress_arb_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  logic [DATA_WIDTH-1:0]  mem_data_q [IN_PORT_NUM][DEPTH];
  logic [DEPTH-1:0]       mem_sop_q  [IN_PORT_NUM];
  logic [DEPTH-1:0]       mem_eop_q  [IN_PORT_NUM];
  logic [AW-1:0]          wr_ptr_q [IN_PORT_NUM];
  logic [AW-1:0]          wr_ptr_d [IN_PORT_NUM];
  logic [AW-1:0]          rd_ptr_q [IN_PORT_NUM];
  logic [AW-1:0]          rd_ptr_d [IN_PORT_NUM];
  logic [CW-1:0]          cnt_q    [IN_PORT_NUM];
  logic [CW-1:0]          cnt_d    [IN_PORT_NUM];
  logic [CW-1:0]          pkt_q    [IN_PORT_NUM];
  logic [CW-1:0]          pkt_d    [IN_PORT_NUM];
  logic [IN_PORT_NUM-1:0] ready_q, ready_d;
  logic [IN_PORT_NUM-1:0] ovf_q, ovf_d;
  logic [IN_PORT_NUM-1:0] we, pop, full, frame_ok, force_eop, elig;
`ifdef MPCACHE_FRM_CHECK_EN
  logic [IN_PORT_NUM-1:0] in_pkt_q, in_pkt_d;
  logic [IN_PORT_NUM-1:0] frm_err_q, frm_err_d;
`endif

  state_t                 state_q;
  logic [PW-1:0]          grant_q, rr_ptr_q, sel_port, rr_next;
  logic                   out_vld_q, any_elig;
  logic [PW:0]            rr_sum, grant_inc;
  logic                   head_sop, head_eop;
  logic [DATA_WIDTH-1:0]  head_data;

  assign head_sop  = mem_sop_q[grant_q][rd_ptr_q[grant_q]];
  assign head_eop  = mem_eop_q[grant_q][rd_ptr_q[grant_q]];
  assign head_data = mem_data_q[grant_q][rd_ptr_q[grant_q]];

  // Per-port write/pop decisions and next-state of counters and status.
  always_comb begin
    for (int p = 0; p < IN_PORT_NUM; p++) begin
      pop[p]       = out_vld_q & bus.out_rdy & (grant_q == PW'(p));
      full[p]      = (cnt_q[p] == CW'(DEPTH));
      frame_ok[p]  = 1'b1;
      force_eop[p] = 1'b0;
`ifdef MPCACHE_FRM_CHECK_EN
      frm_err_d[p] = frm_err_q[p];
      if (bus.wr_vld[p] && !in_pkt_q[p] && !bus.wr_sop[p]) begin
        frame_ok[p]  = 1'b0;
        frm_err_d[p] = 1'b1;
      end else if (bus.wr_vld[p] && in_pkt_q[p] && bus.wr_sop[p]) begin
        // Close the dangling packet on its last word unless that word leaves now.
        force_eop[p] = (cnt_q[p] != {CW{1'b0}}) && !(pop[p] && (cnt_q[p] == CW'(1)));
        frm_err_d[p] = 1'b1;
      end else begin
        frm_err_d[p] = frm_err_q[p];
      end
`endif
      we[p]    = bus.wr_vld[p] & frame_ok[p] & (~full[p] | pop[p]);
      ovf_d[p] = ovf_q[p] | (bus.wr_vld[p] & frame_ok[p] & full[p] & ~pop[p]);
`ifdef MPCACHE_FRM_CHECK_EN
      in_pkt_d[p] = we[p] ? ~bus.wr_eop[p] : in_pkt_q[p];
`endif
      cnt_d[p]    = cnt_q[p] + CW'(we[p]) - CW'(pop[p]);
      wr_ptr_d[p] = we[p]  ? (wr_ptr_q[p] + AW'(1)) : wr_ptr_q[p];
      rd_ptr_d[p] = pop[p] ? (rd_ptr_q[p] + AW'(1)) : rd_ptr_q[p];
      pkt_d[p]    = pkt_q[p] + CW'(we[p] & bus.wr_eop[p]) + CW'(force_eop[p])
                    - CW'(pop[p] & head_eop);
      ready_d[p]  = ((CW'(DEPTH) - cnt_d[p]) > CW'(AF_MARGIN));
      elig[p]     = (pkt_q[p] != {CW{1'b0}});
    end
  end

  // Round-robin pick: scanning backwards leaves the first eligible port at/after rr_ptr.
  always_comb begin
    sel_port = rr_ptr_q;
    any_elig = 1'b0;
    rr_sum   = {(PW+1){1'b0}};
    for (int i = IN_PORT_NUM - 1; i >= 0; i--) begin
      rr_sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (rr_sum >= (PW+1)'(IN_PORT_NUM)) begin
        rr_sum = rr_sum - (PW+1)'(IN_PORT_NUM);
      end else begin
        rr_sum = rr_sum;
      end
      if (elig[rr_sum[PW-1:0]]) begin
        sel_port = rr_sum[PW-1:0];
        any_elig = 1'b1;
      end else begin
        any_elig = any_elig;
      end
    end
    grant_inc = {1'b0, grant_q} + (PW+1)'(1);
    if (grant_inc == (PW+1)'(IN_PORT_NUM)) begin
      rr_next = {PW{1'b0}};
    end else begin
      rr_next = grant_inc[PW-1:0];
    end
  end

  // FIFO storage; contents need no reset because pointers and counters do.
  always_ff @(posedge clk) begin
    for (int p = 0; p < IN_PORT_NUM; p++) begin
      if (we[p]) begin
        mem_data_q[p][wr_ptr_q[p]] <= bus.wr_data[p];
        mem_sop_q[p][wr_ptr_q[p]]  <= bus.wr_sop[p];
        mem_eop_q[p][wr_ptr_q[p]]  <= bus.wr_eop[p];
      end
      if (force_eop[p]) begin
        mem_eop_q[p][wr_ptr_q[p] - AW'(1)] <= 1'b1;
      end
    end
  end

  // Per-port pointer, occupancy, packet count and status registers.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int p = 0; p < IN_PORT_NUM; p++) begin
        wr_ptr_q[p] <= {AW{1'b0}};
        rd_ptr_q[p] <= {AW{1'b0}};
        cnt_q[p]    <= {CW{1'b0}};
        pkt_q[p]    <= {CW{1'b0}};
      end
      ready_q <= {IN_PORT_NUM{1'b1}};
      ovf_q   <= {IN_PORT_NUM{1'b0}};
`ifdef MPCACHE_FRM_CHECK_EN
      in_pkt_q  <= {IN_PORT_NUM{1'b0}};
      frm_err_q <= {IN_PORT_NUM{1'b0}};
`endif
    end else begin
      for (int p = 0; p < IN_PORT_NUM; p++) begin
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
        cnt_q[p]    <= cnt_d[p];
        pkt_q[p]    <= pkt_d[p];
      end
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
`ifdef MPCACHE_FRM_CHECK_EN
      in_pkt_q  <= in_pkt_d;
      frm_err_q <= frm_err_d;
`endif
    end
  end

  // Grant FSM: one IDLE cycle to register the grant, XFER until the eop pops.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      grant_q   <= {PW{1'b0}};
      rr_ptr_q  <= {PW{1'b0}};
      out_vld_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_elig) begin
            grant_q   <= sel_port;
            state_q   <= S_XFER;
            out_vld_q <= 1'b1;
          end else begin
            state_q   <= S_IDLE;
            out_vld_q <= 1'b0;
          end
        end
        S_XFER: begin
          if (bus.out_rdy && head_eop) begin
            rr_ptr_q  <= rr_next;
            state_q   <= S_IDLE;
            out_vld_q <= 1'b0;
          end else begin
            state_q   <= S_XFER;
            out_vld_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          out_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.ovf      = ovf_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_sop  = out_vld_q & head_sop;
  assign bus.out_eop  = out_vld_q & head_eop;
  assign bus.out_data = head_data;
  assign bus.out_port = grant_q;
`ifdef MPCACHE_FRM_CHECK_EN
  assign bus.frm_err  = frm_err_q;
`else
  assign bus.frm_err  = {IN_PORT_NUM{1'b0}};
`endif
endmodule

// File: tb/tb_mp_ingress_arb.sv
// Directed bench for mp_ingress_arb: table of single-packet vectors plus
// hand-written round-robin, backpressure, partial-packet and reset sequences.
module tb_mp_ingress_arb;
  localparam int N     = 16;
  localparam int DW    = 64;
  localparam int DEPTH = 32;
  localparam int AFM   = 4;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  mp_ingress_arb_if #(.IN_PORT_NUM(N), .DATA_WIDTH(DW)) bus();

  mp_ingress_arb #(.IN_PORT_NUM(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    int          len;
    logic [63:0] base;
  } pkt_vec_t;

  pkt_vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.wr_vld = '0;
    bus.wr_sop = '0;
    bus.wr_eop = '0;
    for (int p = 0; p < N; p++) bus.wr_data[p] = '0;
  endtask

  task automatic write_beat(input int p, input logic sop, input logic eop, input logic [63:0] d);
    bus.wr_vld[p]  = 1'b1;
    bus.wr_sop[p]  = sop;
    bus.wr_eop[p]  = eop;
    bus.wr_data[p] = d;
    step();
    clear_in();
  endtask

  task automatic write_pkt(input int p, input int len, input logic [63:0] base);
    for (int i = 0; i < len; i++) write_beat(p, (i == 0), (i == len - 1), base + 64'(i));
  endtask

  function automatic logic [63:0] pdat(input int p);
    return 64'h5500_0000 + 64'(p) * 64'h100;
  endfunction

  task automatic write_multi(input logic [N-1:0] mask, input int len);
    for (int i = 0; i < len; i++) begin
      for (int p = 0; p < N; p++) begin
        if (mask[p]) begin
          bus.wr_vld[p]  = 1'b1;
          bus.wr_sop[p]  = (i == 0);
          bus.wr_eop[p]  = (i == len - 1);
          bus.wr_data[p] = pdat(p) + 64'(i);
        end
      end
      step();
      clear_in();
    end
  endtask

  task automatic wait_vld(input string name, output bit ok);
    int k;
    k = 0;
    while (bus.out_vld !== 1'b1 && k < 64) begin
      step();
      k++;
    end
    ok = (bus.out_vld === 1'b1);
    chk(name, 64'(bus.out_vld), 64'd1);
  endtask

  task automatic collect(input int p, input int len, input logic [63:0] base, input string name);
    bit ok;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < len; i++) begin
      wait_vld({name, "_vld"}, ok);
      if (!ok) return;
      chk({name, "_port"}, 64'(bus.out_port), 64'(p));
      chk({name, "_sop"},  64'(bus.out_sop),  64'(i == 0));
      chk({name, "_eop"},  64'(bus.out_eop),  64'(i == len - 1));
      chk({name, "_data"}, bus.out_data,      base + 64'(i));
      step();
    end
    chk({name, "_bubble"}, 64'(bus.out_vld), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen;
    bit  ok;
    clear_in();
    bus.out_rdy = 1'b1;
    vecs[0] = '{port: 3,  len: 4, base: 64'h3000};
    vecs[1] = '{port: 0,  len: 1, base: 64'h0A00};
    vecs[2] = '{port: 15, len: 2, base: 64'hF000};
    vecs[3] = '{port: 8,  len: 6, base: 64'h8800};
    vecs[4] = '{port: 10, len: 3, base: 64'hA000};

    // Reset state
    rst_in = 1'b1;
    step();
    step();
    chk("rst_ready",   64'(bus.ready),    64'hFFFF);
    chk("rst_out_vld", 64'(bus.out_vld),  64'd0);
    chk("rst_out_sop", 64'(bus.out_sop),  64'd0);
    chk("rst_out_eop", 64'(bus.out_eop),  64'd0);
    chk("rst_out_port",64'(bus.out_port), 64'd0);
    chk("rst_ovf",     64'(bus.ovf),      64'd0);
    chk("rst_frm_err", 64'(bus.frm_err),  64'd0);
    rst_in = 1'b0;
    step();

    // Table: single packets, latency eop(n) -> out_vld(n+2)
    for (int v = 0; v < 5; v++) begin
      write_pkt(vecs[v].port, vecs[v].len, vecs[v].base);
      chk("lat_n1", 64'(bus.out_vld), 64'd0);
      step();
      chk("lat_n2", 64'(bus.out_vld), 64'd1);
      collect(vecs[v].port, vecs[v].len, vecs[v].base, "tbl");
    end

    // Round robin: a port-0 packet leaves rr_ptr=1, then 0/1/2 compete
    write_pkt(0, 1, 64'h0B00);
    collect(0, 1, 64'h0B00, "rr_pre");
    write_multi(16'h0007, 2);
    collect(1, 2, pdat(1), "rr_p1");
    step();
    chk("rr_gap1", 64'(bus.out_vld), 64'd1);
    collect(2, 2, pdat(2), "rr_p2");
    step();
    chk("rr_gap2", 64'(bus.out_vld), 64'd1);
    collect(0, 2, pdat(0), "rr_p0");

    // Partial packet on port 2 must not be granted until its eop
    write_beat(2, 1'b1, 1'b0, 64'h2000);
    write_beat(2, 1'b0, 1'b0, 64'h2001);
    write_beat(2, 1'b0, 1'b0, 64'h2002);
    write_pkt(4, 2, 64'h4000);
    collect(4, 2, 64'h4000, "part_p4");
    seen = 0;
    repeat (6) begin
      step();
      if (bus.out_vld === 1'b1) seen++;
    end
    chk("part_no_grant", 64'(seen), 64'd0);
    write_beat(2, 1'b0, 1'b1, 64'h2003);
    collect(2, 4, 64'h2000, "part_p2");

    // Almost-full and overflow on port 5 with output stalled
    bus.out_rdy = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      write_beat(5, (k == 1), 1'b0, 64'h5000 + 64'(k));
      if (k == 27) chk("af_ready_w27", 64'(bus.ready[5]), 64'd1);
      if (k == 28) chk("af_ready_w28", 64'(bus.ready[5]), 64'd0);
      if (k == 28) chk("af_ready_other", 64'(bus.ready[4]), 64'd1);
      if (k == 32) chk("af_no_ovf_w32", 64'(bus.ovf), 64'd0);
      if (k == 33) chk("af_ovf_w33", 64'(bus.ovf), 64'h0020);
    end

    // Reset in the middle of a stalled transfer
    write_pkt(6, 4, 64'h6000);
    wait_vld("mrst_vld", ok);
    step();
    chk("mrst_stall_vld",  64'(bus.out_vld),  64'd1);
    chk("mrst_stall_data", bus.out_data,      64'h6000);
    chk("mrst_stall_port", 64'(bus.out_port), 64'd6);
    rst_in = 1'b1;
    step();
    chk("mrst_out_vld", 64'(bus.out_vld), 64'd0);
    chk("mrst_ready",   64'(bus.ready),   64'hFFFF);
    chk("mrst_ovf",     64'(bus.ovf),     64'd0);
    chk("mrst_port",    64'(bus.out_port),64'd0);
    rst_in = 1'b0;
    bus.out_rdy = 1'b1;
    seen = 0;
    repeat (8) begin
      step();
      if (bus.out_vld === 1'b1) seen++;
    end
    chk("mrst_no_stale", 64'(seen), 64'd0);
    write_pkt(9, 2, 64'h9000);
    collect(9, 2, 64'h9000, "mrst_p9");

`ifdef MPCACHE_FRM_CHECK_EN
    // Framing: vld without sop outside a packet is dropped and flagged
    write_beat(7, 1'b0, 1'b0, 64'h0BAD);
    chk("frm_err7", 64'(bus.frm_err), 64'h0080);
    write_pkt(7, 2, 64'h7000);
    collect(7, 2, 64'h7000, "frm_p7");
`else
    chk("frm_tied0", 64'(bus.frm_err), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
